// File: rtl/conv_pkg.sv
// Shared definitions for the 32-to-8 width down-converter.
// Word/byte width defaults, state encoding and index-width helper.
package conv_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;
    localparam int NBYTES_DEF = WORD_W_DEF / BYTE_W_DEF;

    // Byte index needs at least one bit even for a 1-byte word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NBYTES_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/conv_hold_reg.sv
// Word-wide holding register with a valid flag (one buffer slot).
// Ports: clk, reset_L, load, clear, d -> q, valid. Load wins over clear.
module conv_hold_reg
    import conv_pkg::*;
#(
    parameter int W = WORD_W_DEF
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_32_8.sv
// Word-to-byte down-converter with a current + pending two-slot buffer.
// Ports: clk, reset_L, valid_in/data_in/ready_in (word side),
// valid_out/data_out/last_out/ready_out (byte side).
// Build option: define LSB_FIRST_EN to emit bytes least-significant first.
module conv_32_8
    import conv_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              ready_in,
    output logic              valid_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              last_out,
    input  logic              ready_out
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int IDX_W  = idx_width(NBYTES);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDX_W-1:0]   idx_next;

    logic [WORD_W-1:0]  cur_data;
    logic [WORD_W-1:0]  pend_data;
    logic [WORD_W-1:0]  cur_d;
    logic               cur_valid;
    logic               pend_valid;
    logic               cur_load;
    logic               cur_from_pend;
    logic               cur_clear;
    logic               pend_load;
    logic               pend_clear;

    logic               accept;
    logic               xfer;
    logic               is_last;

    logic [BYTE_W-1:0]  bytes [NBYTES];

    // ready_in depends only on the pending slot register.
    assign ready_in = !pend_valid;
    assign accept   = valid_in && ready_in;
    assign xfer     = cur_valid && ready_out;
    assign is_last  = (byte_idx == IDX_W'(NBYTES - 1));

    assign cur_d = cur_from_pend ? pend_data : data_in;

    conv_hold_reg #(.W(WORD_W)) u_cur (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (cur_load),
        .clear   (cur_clear),
        .d       (cur_d),
        .q       (cur_data),
        .valid   (cur_valid)
    );

    conv_hold_reg #(.W(WORD_W)) u_pend (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (pend_load),
        .clear   (pend_clear),
        .d       (data_in),
        .q       (pend_data),
        .valid   (pend_valid)
    );

    // Byte g is the g-th byte to leave the block.
    for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
`ifdef LSB_FIRST_EN
        assign bytes[g] = cur_data[g*BYTE_W +: BYTE_W];
`else
        assign bytes[g] = cur_data[WORD_W-1-g*BYTE_W -: BYTE_W];
`endif
    end

    assign valid_out = cur_valid;
    assign data_out  = cur_valid ? bytes[byte_idx] : '0;
    assign last_out  = cur_valid && is_last;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_next;
            byte_idx <= idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = byte_idx;
        cur_load      = 1'b0;
        cur_from_pend = 1'b0;
        cur_clear     = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cur_load   = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer && is_last) begin
                    idx_next = '0;
                    // Pending word takes priority; ready_in is low then,
                    // so no accept can coincide with it.
                    if (pend_valid) begin
                        cur_load      = 1'b1;
                        cur_from_pend = 1'b1;
                        pend_clear    = 1'b1;
                    end else if (accept) begin
                        cur_load = 1'b1;
                    end else begin
                        cur_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_next = byte_idx + 1'b1;
                    end
                    if (accept) begin
                        pend_load = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule
